// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One iteration per clock. MULT/MULTU use shift-add. DIV/DIVU use restoring
// shift-subtract. A sign fix-up cycle then writes HI/LO.
// Optional build macro MDU_EARLY_OUT_EN: multiplies leave RUN as soon as no
// multiplier bits remain to be consumed.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   start, op   - launch (IDLE only); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a/src_b - multiplicand/dividend and multiplier/divisor
//   mthi/mtlo   - move src_a into HI/LO while idle
//   hi_out/lo_out, busy, done - registered outputs
module mult_div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   input  logic                  mthi,
   input  logic                  mtlo,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DATA_WIDTH-1:0] lo_out,
   output logic                  busy,
   output logic                  done
);

   localparam int DW = DATA_WIDTH;
   localparam int W2 = 2 * DATA_WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 is_div;
   logic                 is_sgn;
   logic                 sign_a;
   logic                 sign_b;
   logic                 div_zero;
   // Multiply: running product. Divide: {remainder, dividend/quotient}.
   logic [W2-1:0]        acc;
   // Multiply only: multiplicand magnitude, shifted left each step.
   logic [W2-1:0]        mcand;
   // Multiply: multiplier magnitude, shifted right. Divide: divisor.
   logic [DW-1:0]        mplr;
   logic [DW-1:0]        hi_q;
   logic [DW-1:0]        lo_q;
   logic                 done_q;

   // Operand capture
   logic          in_sgn;
   logic          in_neg_a;
   logic          in_neg_b;
   logic [DW-1:0] in_mag_a;
   logic [DW-1:0] in_mag_b;

   always_comb begin
      in_sgn   = ~op[0];
      in_neg_a = in_sgn & src_a[DW-1];
      in_neg_b = in_sgn & src_b[DW-1];
      in_mag_a = in_neg_a ? (~src_a + 1'b1) : src_a;
      in_mag_b = in_neg_b ? (~src_b + 1'b1) : src_b;
   end

   // Iteration step
   logic [W2-1:0] mul_next;
   logic [DW+1:0] trial;
   logic [W2-1:0] div_next;
   logic          last_run;
   logic          mul_exit;

   always_comb begin
      mul_next = acc + (mplr[0] ? mcand : '0);
      // Shifted partial remainder may need DW+1 bits; one more bit for borrow.
      trial    = {1'b0, acc[W2-1:DW-1]} - {2'b00, mplr};
      if (!trial[DW+1])
         div_next = {trial[DW-1:0], acc[DW-2:0], 1'b1};
      else
         div_next = {acc[W2-2:0], 1'b0};
      last_run = (cnt == CNT_WIDTH'(DW - 1));
`ifdef MDU_EARLY_OUT_EN
      mul_exit = ~is_div & (mplr[DW-1:1] == '0);
`else
      mul_exit = 1'b0;
`endif
   end

   // Sign fix-up
   logic [W2-1:0] prod_fix;
   logic [DW-1:0] quo_fix;
   logic [DW-1:0] rem_fix;

   always_comb begin
      if (is_sgn & (sign_a ^ sign_b))
         prod_fix = ~acc + 1'b1;
      else
         prod_fix = acc;
      if (div_zero)
         quo_fix = '1;
      else if (is_sgn & (sign_a ^ sign_b))
         quo_fix = ~acc[DW-1:0] + 1'b1;
      else
         quo_fix = acc[DW-1:0];
      // Remainder takes the dividend's sign (truncating division).
      if (is_sgn & sign_a)
         rem_fix = ~acc[W2-1:DW] + 1'b1;
      else
         rem_fix = acc[W2-1:DW];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         is_sgn   <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplr     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_RUN;
                  cnt      <= '0;
                  is_div   <= op[1];
                  is_sgn   <= in_sgn;
                  sign_a   <= in_neg_a;
                  sign_b   <= in_neg_b;
                  div_zero <= op[1] & (src_b == '0);
                  mplr     <= in_mag_b;
                  mcand    <= {{DW{1'b0}}, in_mag_a};
                  acc      <= op[1] ? {{DW{1'b0}}, in_mag_a} : '0;
               end else begin
                  if (mthi) hi_q <= src_a;
                  if (mtlo) lo_q <= src_a;
               end
            end
            S_RUN: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  acc <= div_next;
               end else begin
                  acc   <= mul_next;
                  mcand <= mcand << 1;
                  mplr  <= mplr >> 1;
               end
               if (last_run || mul_exit)
                  state <= S_FIX;
            end
            S_FIX: begin
               state  <= S_IDLE;
               done_q <= 1'b1;
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[W2-1:DW];
                  lo_q <= prod_fix[DW-1:0];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;
   assign busy   = (state != S_IDLE);
   assign done   = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO and latency are queued
// at launch and compared when done rises.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        done;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [63:0] exp_q[$];
   int          lat_q[$];

`ifdef MDU_EARLY_OUT_EN
   localparam int PULSE = 1;
`else
   localparam int PULSE = 5;
`endif

   mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
      logic [31:0] m;
      int bl;
      exp_lat = 33;
`ifdef MDU_EARLY_OUT_EN
      if (!o[1]) begin
         m = (o == 2'b00 && b[31]) ? (~b + 1) : b;
         bl = 0;
         for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
         exp_lat = ((bl < 1) ? 1 : bl) + 1;
      end
`else
      m = b;
      bl = 0;
      if (o == 2'b00 && m == 32'd1 && bl == 1) exp_lat = 0;
`endif
   endfunction

   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] a, b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      model = '0;
      case (o)
         2'b00: model = sa * sb;
         2'b01: model = ua * ub;
         2'b10: begin
            if (b == 0) model = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               model = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) model = {a, 32'hFFFF_FFFF};
            else model = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] a, b,
                         input logic [63:0] want, input bit push);
      if (push) begin
         exp_q.push_back(want);
         lat_q.push_back(exp_lat(o, b));
      end
      @(negedge clk);
      start = 1'b1;
      op = o;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_done(input string tag);
      logic [63:0] e;
      int l;
      while (!done && cyc < 200) step();
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " hilo"}, {hi_out, lo_out}, e);
      check({tag, " lat"}, 64'(cyc), 64'(l));
      check({tag, " busy"}, 64'(busy), 64'd0);
      step();
      check({tag, " pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int seen;

      repeat (2) @(posedge clk);
      #1;
      check("rst hi", 64'(hi_out), 64'd0);
      check("rst lo", 64'(lo_out), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Moves
      @(negedge clk);
      mthi = 1'b1;
      src_a = 32'h1234;
      @(posedge clk);
      #1;
      mthi = 1'b0;
      check("mthi", 64'(hi_out), 64'h1234);
      check("mthi lo", 64'(lo_out), 64'd0);
      @(negedge clk);
      mthi = 1'b1;
      mtlo = 1'b1;
      src_a = 32'hABCD;
      @(posedge clk);
      #1;
      mthi = 1'b0;
      mtlo = 1'b0;
      check("mt both", {hi_out, lo_out}, {32'hABCD, 32'hABCD});

      // Start and mthi together: start wins, HI untouched until FIX
      mthi = 1'b1;
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             {32'hFFFF_FFFE, 32'h0000_0001}, 1);
      mthi = 1'b0;
      check("drop mthi", 64'(hi_out), 64'hABCD);
      check("busy run", 64'(busy), 64'd1);
      while (cyc < 16 && !done) step();
`ifndef MDU_EARLY_OUT_EN
      check("hold hilo", {hi_out, lo_out}, {32'hABCD, 32'hABCD});
`endif
      wait_done("multu max");

      launch(2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1);
      wait_done("mult -3x7");
      launch(2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0}, 1);
      wait_done("mult min");
      launch(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
      wait_done("div -7/2");
      launch(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
      wait_done("divu 100/7");
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1);
      wait_done("div ovf");
      launch(2'b11, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
      wait_done("divu by0");
      launch(2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1);
      wait_done("div by0");

      // start and mtlo while busy are ignored
      launch(2'b01, 32'd2, 32'd3, {32'd0, 32'd6}, 1);
      repeat (PULSE - 1) step();
      start = 1'b1;
      op = 2'b11;
      mtlo = 1'b1;
      src_a = 32'hDEAD;
      src_b = 32'd1;
      step();
      start = 1'b0;
      mtlo = 1'b0;
      check("pulse busy", 64'(busy), 64'd1);
      wait_done("ignore");
      check("ignore idle", 64'(busy), 64'd0);

      // Reset mid-run
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 0);
      repeat (10) step();
      rst = 1'b1;
      #1;
      check("arst busy", 64'(busy), 64'd0);
      check("arst hilo", {hi_out, lo_out}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      check("arst quiet", 64'(seen), 64'd0);

      // Randomised ops against the model
      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : ((i == 5) ? 32'($urandom_range(0, 300)) : $urandom);
         launch(ro, ra, rb, model(ro, ra, rb), 1);
         wait_done("rand");
      end

      // Short multipliers (early exit when enabled)
      launch(2'b01, 32'd5, 32'd3, {32'd0, 32'd15}, 1);
      wait_done("multu 5x3");
      launch(2'b01, 32'h89AB_CDEF, 32'd0, 64'd0, 1);
      wait_done("multu x0");
      launch(2'b00, 32'd9, 32'hFFFF_FFFE, model(2'b00, 32'd9, 32'hFFFF_FFFE), 1);
      wait_done("mult 9x-2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file: src_a/src_b are driven by RD1/RD2 and consumed for MULT, MULTU, DIV and DIVU.
- hi_out/lo_out feed the writeback mux for MFHI/MFLO.
- Processes one bit per cycle; the control unit stalls the pipeline while busy is high.

Parameters:
- DATA_WIDTH, 32, operand width and width of each of HI and LO.
- CNT_WIDTH, 5, iteration counter width; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clock clk.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
- src_a  input  DATA_WIDTH  multiplicand/dividend (from RD1).
- src_b  input  DATA_WIDTH  multiplier/divisor (from RD2).
- mthi  input  1  write src_a into HI.
- mtlo  input  1  write src_a into LO.
- hi_out  output  DATA_WIDTH  current HI register.
- lo_out  output  DATA_WIDTH  current LO register.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse in the cycle after HI/LO are updated by an operation.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, HI=0, LO=0, counter=0, busy=0, done=0.
  - The in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start=1 at edge E0: latch op, sign flags, magnitudes |src_a| and |src_b| (raw values for unsigned ops); clear accumulator/remainder; counter=0; go to RUN.
  - Else, if mthi/mtlo is set, write src_a into HI and/or LO at that edge. Both set means both are written.
- RUN:
  - One iteration per edge, counter increments each edge.
  - Multiply: shift-add on the 64-bit unsigned magnitude product.
  - Divide: restoring shift-subtract giving unsigned quotient and remainder.
  - After the edge on which counter=DATA_WIDTH-1 (32 RUN edges, E1..E32), go to FIX.
- FIX (edge E33):
  - Apply sign correction and write HI/LO; go to IDLE; done=1 for the following cycle.
  - Multiply: {HI,LO} = 64-bit product, two's-complement negated if signed and sign_a^sign_b.
  - Divide: LO = quotient, negated if signed and sign_a^sign_b. HI = remainder, negated if signed and sign_a (truncating division).
- Latency: HI/LO hold the new result 33 edges after the start edge.
  - busy is high for cycles after E0 through E32.
  - busy is low and done is high after E33.
- Divide by zero (src_b=0, DIV or DIVU): HI=src_a (unmodified value), LO=all ones. Same latency, no exception.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps naturally).
- start while busy is ignored; the operation in flight is unaffected.
- mthi/mtlo while busy are ignored.
- start and mthi/mtlo in the same IDLE cycle: start wins, the move is dropped.
- HI/LO are not altered until FIX. hi_out/lo_out show old values throughout RUN.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Multiplies (MULT, MULTU) leave RUN after the first edge at which the remaining unshifted multiplier magnitude bits are all zero.
  - Minimum is 1 RUN edge, so RUN edges = max(1, bit-length of |src_b|).
  - Total latency = RUN edges + 1 edges after the start edge.
  - Divides are unaffected (always 32 RUN edges).
- Undefined: every operation takes exactly 32 RUN edges; no early-exit logic is present.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001 exactly 33 edges after start.
  - done high exactly one cycle; busy low afterwards.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV signed and unsigned:
  - DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 7 -> LO=14, HI=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF, standard latency.
- Moves and ignored inputs:
  - mthi with src_a=0x1234 in IDLE -> hi_out=0x1234 next edge.
  - Start MULTU 2 x 3, then pulse start (op=DIVU) and mtlo at cycle 5 -> both ignored; final HI=0, LO=6.
- Reset and early-out:
  - Assert rst at RUN cycle 10 -> busy=0, HI=LO=0 immediately; no done pulse for 40 cycles.
  - With MDU_EARLY_OUT_EN: MULTU 5 x 3 -> LO=15, HI=0, done after 3 edges from start.
  - With MDU_EARLY_OUT_EN: MULTU x 0 -> result 0 after 2 edges.
